accel_seq_ctrl: RTL
===================

// Module: accel_seq_ctrl
// PURPOSE
//  Transaction sequencer for the ADXL362 accelerometer behind the byte-level SPI engine.
//  After reset it waits for sensor power-up and writes FILTER_CTL (0x2C) then POWER_CTL (0x2D).
//  It then reads XDATA (0x08) and YDATA (0x09) as one burst every SAMPLE_PERIOD cycles.
//  Registered 8-bit X/Y samples go to accelerometr_ctrl consumers; a watchdog restarts configuration on a stalled engine.
// PARAMETERS
//  POWERUP_CYCLES  25000   cycles to wait after reset/restart before first write (5 ms @ 5 MHz)
//  SAMPLE_PERIOD   50000   cycles from start of one read burst to start of the next (10 ms)
//  TIMEOUT_CYCLES  255     max cycles waiting for byte_done before abort
//  FILTER_CTL_VAL  8'h13   value written to register 0x2C
//  POWER_CTL_VAL   8'h02   value written to register 0x2D (measurement mode)
// PORTS
//  spi_clk       in   1  single clock (5 MHz); all logic on rising edge
//  rst           in   1  synchronous reset, active high
//  enable        in   1  1 = periodic sampling allowed
//  byte_start    out  1  one-cycle pulse: engine shifts byte_tx
//  byte_tx       out  8  byte to send; stable from byte_start until byte_done
//  byte_last     out  1  with byte_start: engine raises CSN after this byte
//  byte_done     in   1  one-cycle pulse: byte finished, byte_rx valid
//  byte_rx       in   8  byte received during the finished transfer
//  accel_data_x  out  8  latest X sample
//  accel_data_y  out  8  latest Y sample
//  data_valid    out  1  one-cycle pulse when X/Y update
//  cfg_done      out  1  level: both config writes completed since last (re)start
//  timeout_err   out  1  sticky: set on watchdog expiry; cleared only by rst
// BEHAVIOUR
//  Reset: every output 0 (byte_tx=8'h00, accel_data_x/y=8'h00); state PWRUP; all counters 0.
//  States: PWRUP -> W_CMD -> W_ADDR -> W_DATA -> (second write: W_CMD) -> IDLE -> R_CMD -> R_ADDR -> R_X -> R_Y -> UPDATE -> IDLE.
//  - PWRUP: count POWERUP_CYCLES cycles, then W_CMD with cfg index 0.
//  - Write frame: bytes 0x0A, addr, value; byte_last=1 on value byte only.
//  - Write order: index 0 = 0x2C/FILTER_CTL_VAL; index 1 = 0x2D/POWER_CTL_VAL. After index 1 W_DATA done: cfg_done<=1, enter IDLE, period counter 0.
//  - Read frame: bytes 0x0B, 0x08, dummy 0x00 (rx -> X holding reg), dummy 0x00 with byte_last=1 (rx -> Y holding reg).
//  - UPDATE: one cycle; load accel_data_x/y from holding regs; data_valid=1; return to IDLE.
//  - IDLE: period counter runs from the cycle R_CMD's byte_start is issued.
//    Start R_CMD when counter reaches SAMPLE_PERIOD-1 and enable=1; first burst starts on the cycle after entering IDLE if enable=1.
//    enable=0 holds in IDLE with counter saturated; burst starts on the cycle after enable rises.
//  - enable falling mid-burst: burst completes, UPDATE occurs, then stays in IDLE.
//  Byte handshake:
//  - each byte state issues byte_start for exactly one cycle on entry, then waits for byte_done.
//  - advance on the cycle after byte_done; next byte_start no earlier than that cycle (min 1 idle cycle between done and start).
//  - byte_done while no byte outstanding: ignored.
//  - byte_rx is sampled only in the byte_done cycle.
//  Watchdog:
//  - counter clears at byte_start and increments each cycle while waiting.
//  - at TIMEOUT_CYCLES with no byte_done: timeout_err<=1, cfg_done<=0, go to PWRUP; outputs X/Y keep last values; no data_valid.
//  - byte_done arriving in the same cycle as expiry counts as done (no timeout).
//  Counters sized $clog2(max param)+1; no wrap: each counter stops at terminal value.
//  rst asserted mid-frame: next edge forces reset state; CSN recovery is the engine's job (engine shares rst).
// TESTING
//  - Reset/config: rst 3 cycles, engine model done 16 cycles after start -> 6 byte_starts, tx 0A,2C,13,0A,2D,02; byte_last on 3rd and 6th only; first start at cycle POWERUP_CYCLES; cfg_done=1 after 6th done.
//  - Sample: model returns rx 00,00,5A,A5 on read frame -> tx 0B,08,00,00; accel_data_x=8'h5A, accel_data_y=8'hA5, data_valid high exactly 1 cycle.
//  - Period: SAMPLE_PERIOD=100, enable=1 -> consecutive R_CMD byte_start pulses exactly 100 cycles apart over 5 bursts.
//  - Enable: drop enable during R_ADDR -> burst finishes with one data_valid, then no byte_start for 1000 cycles; raise enable -> byte_start the next cycle.
//  - Timeout: model withholds byte_done on R_X -> after TIMEOUT_CYCLES timeout_err=1, cfg_done=0, X/Y unchanged; config rewritten after POWERUP_CYCLES.
//  - Mid-op reset: assert rst during W_DATA -> next cycle all outputs 0, state PWRUP; stray byte_done after reset ignored.

Source files
------------

// File: rtl/accel_seq_ctrl.sv
// ADXL362 transaction sequencer: power-up wait, two configuration writes, then
// periodic XDATA/YDATA burst reads through a byte-level SPI engine, with a byte watchdog.
module accel_seq_ctrl #(
   parameter int unsigned POWERUP_CYCLES = 25000,
   parameter int unsigned SAMPLE_PERIOD  = 50000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [7:0]  FILTER_CTL_VAL = 8'h13,
   parameter logic [7:0]  POWER_CTL_VAL  = 8'h02
) (
   input  logic       spi_clk,
   input  logic       rst,
   input  logic       enable,
   output logic       byte_start,
   output logic [7:0] byte_tx,
   output logic       byte_last,
   input  logic       byte_done,
   input  logic [7:0] byte_rx,
   output logic [7:0] accel_data_x,
   output logic [7:0] accel_data_y,
   output logic       data_valid,
   output logic       cfg_done,
   output logic       timeout_err
);

   localparam logic [3:0] S_PWRUP  = 4'd0;
   localparam logic [3:0] S_W_CMD  = 4'd1;
   localparam logic [3:0] S_W_ADDR = 4'd2;
   localparam logic [3:0] S_W_DATA = 4'd3;
   localparam logic [3:0] S_IDLE   = 4'd4;
   localparam logic [3:0] S_R_CMD  = 4'd5;
   localparam logic [3:0] S_R_ADDR = 4'd6;
   localparam logic [3:0] S_R_X    = 4'd7;
   localparam logic [3:0] S_R_Y    = 4'd8;
   localparam logic [3:0] S_UPDATE = 4'd9;

   localparam logic [7:0] CMD_WRITE  = 8'h0A;
   localparam logic [7:0] CMD_READ   = 8'h0B;
   localparam logic [7:0] REG_FILTER = 8'h2C;
   localparam logic [7:0] REG_POWER  = 8'h2D;
   localparam logic [7:0] REG_XDATA  = 8'h08;

   localparam int unsigned CNT_MAX = (POWERUP_CYCLES > SAMPLE_PERIOD) ? POWERUP_CYCLES : SAMPLE_PERIOD;
   localparam int CW = $clog2(CNT_MAX) + 1;
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] PWRUP_LAST  = CW'(POWERUP_CYCLES - 1);
   localparam logic [CW-1:0] PERIOD_LAST = CW'(SAMPLE_PERIOD - 1);
   localparam logic [WW-1:0] WD_LAST     = WW'(TIMEOUT_CYCLES - 1);

   logic [3:0]    state, nxt;
   logic          busy;          // a byte is outstanding at the engine
   logic          cfg_idx;       // 0: FILTER_CTL write, 1: POWER_CTL write
   logic          first_burst;   // first read after configuration skips the period wait
   logic          issue;
   logic [CW-1:0] cnt, cnt_lim;
   logic [WW-1:0] wd;
   logic [7:0]    x_hold, y_hold, nxt_tx;
   logic          nxt_last;

   // Byte states only advance once the outstanding byte has completed.
   always_comb begin
      nxt = state;
      case (state)
         S_PWRUP:  if (cnt == PWRUP_LAST) nxt = S_W_CMD;
         S_W_CMD:  if (!busy) nxt = S_W_ADDR;
         S_W_ADDR: if (!busy) nxt = S_W_DATA;
         S_W_DATA: if (!busy) nxt = cfg_idx ? S_IDLE : S_W_CMD;
         S_IDLE:   if (enable && (first_burst || cnt == PERIOD_LAST)) nxt = S_R_CMD;
         S_R_CMD:  if (!busy) nxt = S_R_ADDR;
         S_R_ADDR: if (!busy) nxt = S_R_X;
         S_R_X:    if (!busy) nxt = S_R_Y;
         S_R_Y:    if (!busy) nxt = S_UPDATE;
         S_UPDATE: nxt = S_IDLE;
         default:  nxt = S_PWRUP;
      endcase
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      nxt_tx   = 8'h00;
      nxt_last = 1'b0;
      case (nxt)
         S_W_CMD:  nxt_tx = CMD_WRITE;
         S_W_ADDR: nxt_tx = cfg_idx ? REG_POWER : REG_FILTER;
         S_W_DATA: begin
            nxt_tx   = cfg_idx ? POWER_CTL_VAL : FILTER_CTL_VAL;
            nxt_last = 1'b1;
         end
         S_R_CMD:  nxt_tx = CMD_READ;
         S_R_ADDR: nxt_tx = REG_XDATA;
         S_R_Y:    nxt_last = 1'b1;
         default:  ;
      endcase
   end

   assign issue   = (nxt != state) && (nxt inside {S_W_CMD, S_W_ADDR, S_W_DATA,
                                                   S_R_CMD, S_R_ADDR, S_R_X, S_R_Y});
   assign cnt_lim = (state == S_PWRUP) ? PWRUP_LAST : PERIOD_LAST;

   always_ff @(posedge spi_clk) begin
      if (rst) begin
         state        <= S_PWRUP;
         busy         <= 1'b0;
         cfg_idx      <= 1'b0;
         first_burst  <= 1'b0;
         cnt          <= '0;
         wd           <= '0;
         x_hold       <= 8'h00;
         y_hold       <= 8'h00;
         byte_start   <= 1'b0;
         byte_tx      <= 8'h00;
         byte_last    <= 1'b0;
         accel_data_x <= 8'h00;
         accel_data_y <= 8'h00;
         data_valid   <= 1'b0;
         cfg_done     <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         byte_start <= 1'b0;
         data_valid <= 1'b0;
         // NOTE: the saturating increment comes first; later non-blocking writes to cnt override it.
         if (cnt < cnt_lim) cnt <= cnt + 1'b1;

         if (busy) begin
            if (byte_done) begin
               busy <= 1'b0;
               if (state == S_R_X) x_hold <= byte_rx;
               if (state == S_R_Y) y_hold <= byte_rx;
            end else if (wd == WD_LAST) begin
               timeout_err <= 1'b1;
               cfg_done    <= 1'b0;
               state       <= S_PWRUP;
               busy        <= 1'b0;
               cfg_idx     <= 1'b0;
               first_burst <= 1'b0;
               cnt         <= '0;
            end else begin
               wd <= wd + 1'b1;
            end
         end else begin
            state <= nxt;
            if (issue) begin
               byte_start <= 1'b1;
               byte_tx    <= nxt_tx;
               byte_last  <= nxt_last;
               busy       <= 1'b1;
               wd         <= '0;
            end
            if (state == S_IDLE && nxt == S_R_CMD) begin
               cnt         <= '0;
               first_burst <= 1'b0;
            end
            if (state == S_W_DATA) begin
               if (cfg_idx) begin
                  cfg_done    <= 1'b1;
                  cnt         <= '0;
                  first_burst <= 1'b1;
               end else begin
                  cfg_idx <= 1'b1;
               end
            end
            if (state == S_UPDATE) begin
               accel_data_x <= x_hold;
               accel_data_y <= y_hold;
               data_valid   <= 1'b1;
            end
         end
      end
   end

endmodule
